// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // Byte enables for an access; halfwords and words are forced to natural alignment.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] pack_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] packed_wd;
        case (size)
            SZ_BYTE: packed_wd = {4{wd[7:0]}};
            SZ_HALF: packed_wd = {2{wd[15:0]}};
            default: packed_wd = wd;
        endcase
        return packed_wd;
    endfunction

endpackage

// File: rtl/lsu_extract_module.sv
// Load-data lane select with sign/zero extension (purely combinational).
module lsu_extract_module
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign_en,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        data     = mem_rdata;
        case (size)
            SZ_BYTE: data = {{24{sign_en & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{sign_en & half_sel[15]}}, half_sel};
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_module.sv
// Single-outstanding load/store unit: IDLE -> REQ -> DONE with a ready-gated memory port.
// Optional macro LSU_MISALIGN_CHECK_EN flags misaligned halfword/word accesses as errors.
module lsu_module
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_store,
    input  logic [1:0]  size,
    input  logic        sign_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [1:0]  dbg_state
);

    // Memory handshake: the request (mem_req plus attributes) is held unchanged from the
    // first REQ cycle until the cycle in which mem_ready is sampled high; that cycle completes it.

    lsu_state_e  state_q, state_d;
    logic        op_store_q;
    logic [1:0]  size_q;
    logic        sign_en_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        misaligned;
    logic        legal;
    logic        accept;
    logic [31:0] ext_data;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = ((size == SZ_HALF) && addr[0]) ||
                        ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign legal  = (size != SZ_ILL) && !misaligned;
    assign accept = start && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = legal ? ST_REQ : ST_DONE;
            ST_REQ:  if (mem_ready) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_store_q <= 1'b0;
            size_q     <= SZ_BYTE;
            sign_en_q  <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_store_q <= op_store;
                size_q     <= size;
                sign_en_q  <= sign_en;
                addr_q     <= addr;
                wdata_q    <= wdata;
                err_q      <= !legal;
            end
            if ((state_q == ST_REQ) && mem_ready && !op_store_q) begin
                rdata_q <= ext_data;
            end
        end
    end

    lsu_extract_module u_extract (
        .mem_rdata (mem_rdata),
        .addr      (addr_q[1:0]),
        .size      (size_q),
        .sign_en   (sign_en_q),
        .data      (ext_data)
    );

    // Attributes come straight from the latched request, so they cannot move while waiting.
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_req && op_store_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = mem_req ? lane_be(size_q, addr_q[1:0]) : 4'b0000;
    assign mem_wdata = pack_wdata(size_q, wdata_q);

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_module.sv
// Scoreboard bench for lsu_module: random accesses against a byte-level memory reference model.
`timescale 1ns/1ps
module tb_lsu_module;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    lsu_module dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_store  (op_store),
        .size      (size),
        .sign_en   (sign_en),
        .addr      (addr),
        .wdata     (wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .dbg_state (dbg_state)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          start_cyc;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [31:0] mem_words [logic [31:0]];

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          resp_waits = 0;
    logic [31:0] model_rdata = 32'd0;
    logic        idle_err = 1'b0;
    logic [31:0] idle_rdata = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_word(input logic [31:0] a);
        if (!mem_words.exists(a)) mem_words[a] = $urandom;
        return mem_words[a];
    endfunction

    function automatic bit model_legal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if (sz == 2'd1 && (a % 2) != 0) return 1'b0;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Reference load: pick the bytes by address arithmetic, then extend numerically.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input bit sg, input logic [31:0] a);
        int nb, off;
        logic [63:0] v, m;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = (sz == 2'd0) ? int'(a % 4) : (sz == 2'd1) ? int'((a % 4) / 2) * 2 : 0;
        v   = {32'd0, word} >> (8 * off);
        m   = (64'd1 << (8 * nb)) - 64'd1;
        v   = v & m;
        if (sg && nb < 4 && v >= (m + 64'd1) / 2) v = v + (64'hFFFF_FFFF - m);
        return v[31:0];
    endfunction

    // Memory responder: checks the request, its stability while waiting, and returns data.
    int          rcnt = 0;
    req_t        cur;
    req_t        hold;
    always @(negedge clk) begin
        if (!rst_n) begin
            rcnt = 0;
            mem_ready = 1'b0;
        end else if (mem_req) begin
            if (rcnt == 0) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                    cur = '{we: 1'b0, addr: mem_addr, be: 4'b0, wdata: 32'd0};
                end else begin
                    cur = req_q.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(cur.we));
                    chk("mem_addr", mem_addr, cur.addr);
                    if (cur.we) begin
                        chk("mem_be", 32'(mem_be), 32'(cur.be));
                        chk("mem_wdata", mem_wdata, cur.wdata);
                    end
                end
                hold = '{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata};
            end else begin
                chk("stable_we", 32'(mem_we), 32'(hold.we));
                chk("stable_addr", mem_addr, hold.addr);
                chk("stable_be", 32'(mem_be), 32'(hold.be));
                chk("stable_wdata", mem_wdata, hold.wdata);
            end
            if (rcnt >= resp_waits) begin
                mem_ready = 1'b1;
                mem_rdata = get_word(cur.addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
            rcnt++;
        end else begin
            rcnt = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end
    end

    // Monitor: pops an expectation for every done pulse; checks held outputs while idle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("err", 32'(err), 32'(e.err));
                    chk("rdata", rdata, e.rdata);
                    chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    chk("busy_in_done", 32'(busy), 32'd1);
                    idle_err   = e.err;
                    idle_rdata = e.rdata;
                end
            end else if (!busy) begin
                chk("idle_err_hold", 32'(err), 32'(idle_err));
                chk("idle_rdata_hold", rdata, idle_rdata);
            end
        end
    end

    task automatic issue(input bit st, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                         input logic [31:0] wd, input int waits, input bit extra);
        exp_t e;
        req_t r;
        bit   legal;
        int   prev, t;
        t = 0;
        while (busy && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        legal = model_legal(sz, a);
        if (legal && !st) model_rdata = model_load(get_word(a & ~32'd3), sz, sg, a);
        e.err       = !legal;
        e.rdata     = model_rdata;
        e.start_cyc = cyc;
        e.lat       = legal ? 2 + waits : 1;
        exp_q.push_back(e);
        if (legal) begin
            r.we   = st;
            r.addr = a & ~32'd3;
            case (sz)
                2'd0: begin r.be = 4'd1 << (a % 4);          r.wdata = {24'd0, wd[7:0]} * 32'h0101_0101; end
                2'd1: begin r.be = 4'd3 << (2 * ((a / 2) % 2)); r.wdata = {16'd0, wd[15:0]} * 32'h0001_0001; end
                default: begin r.be = 4'hF;                  r.wdata = wd; end
            endcase
            req_q.push_back(r);
        end
        resp_waits = waits;
        prev = done_cnt;
        start = 1'b1; op_store = st; size = sz; sign_en = sg; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0;
        op_store = 1'($urandom); size = 2'($urandom); sign_en = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        if (extra) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        t = 0;
        while (done_cnt == prev && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_cnt == prev) chk("done_timeout", 32'd1, 32'd0);
        if (extra) begin
            repeat (3) @(posedge clk);
            #1;
            chk("single_done", 32'(done_cnt - prev), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] a;
        req_t        r;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        mem_words[32'h1000] = 32'h80FF_0000;
        mem_words[32'h2000] = 32'hBEEF_1234;

        issue(1'b0, 2'd0, 1'b1, 32'h1003, $urandom, 0, 1'b0);
        chk("lb_sign_rdata", rdata, 32'hFFFF_FF80);
        issue(1'b0, 2'd1, 1'b0, 32'h2002, $urandom, 1, 1'b0);
        chk("lh_zero_rdata", rdata, 32'h0000_BEEF);
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'hAABB_CCDD, 3, 1'b0);
        chk("sb_keeps_rdata", rdata, 32'h0000_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h6, $urandom, 0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h6, 32'h1234_5678, 2, 1'b0);
        issue(1'b0, 2'd3, 1'b1, 32'h40, $urandom, 0, 1'b0);
        chk("illegal_err_hold", 32'(err), 32'd1);
        issue(1'b1, 2'd2, 1'b0, 32'h80, $urandom, 2, 1'b1);
        issue(1'b0, 2'd3, 1'b0, 32'h84, $urandom, 0, 1'b1);

        // Reset while a load is waiting on mem_ready.
        a = 32'h300;
        r = '{we: 1'b0, addr: a, be: 4'hF, wdata: 32'd0};
        req_q.push_back(r);
        resp_waits = 20;
        start = 1'b1; op_store = 1'b0; size = 2'd2; sign_en = 1'b0; addr = a;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_mem_wdata", mem_wdata, 32'd0);
        chk("midrst_mem_be", 32'(mem_be), 32'd0);
        exp_q.delete();
        req_q.delete();
        model_rdata = 32'd0;
        idle_err    = 1'b0;
        idle_rdata  = 32'd0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 2'd1, 1'b1, 32'h2002, $urandom, 0, 1'b0);
        chk("post_rst_rdata", rdata, 32'hFFFF_BEEF);

        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)),
                  $urandom, $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
